// File: rtl/calc_pkg.sv
// calc_pkg
//   Shared definitions for the calculator execution core. It holds the opcode
//   encodings, the sequencer state enum and the helpers that derive the
//   instruction and immediate widths from the register count.
package calc_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } calc_state_e;

  // Register index width. It is clamped to one bit so that a degenerate NREG
  // still gives legal vector widths.
  function automatic int ridx_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // Instruction layout is {op[1:0], ra, rb, rc}.
  function automatic int inst_w(input int nreg);
    return 2 + 3 * ridx_w(nreg);
  endfunction

  // A PUSH immediate is the concatenation {rb, rc}.
  function automatic int imm_w(input int nreg);
    return 2 * ridx_w(nreg);
  endfunction

endpackage

// File: rtl/calc_if.sv
// calc_if
//   Groups the instruction handshake, the transmit handshake and the status
//   signals of calc_exec_core.
//   master: the instruction source and transmitter side. It drives inst,
//           inst_vld and tx_rdy.
//   slave : the execution core. It drives inst_rdy, tx_data, tx_vld,
//           exec_pulse, exec_inst, ovf and busy.
interface calc_if
  import calc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
);

  localparam int INST_W = inst_w(NREG);

  logic [INST_W-1:0] inst;
  logic              inst_vld;
  logic              inst_rdy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_vld;
  logic              tx_rdy;
  logic              exec_pulse;
  logic [INST_W-1:0] exec_inst;
  logic              ovf;
  logic              busy;

  modport master (
    output inst, inst_vld, tx_rdy,
    input  inst_rdy, tx_data, tx_vld, exec_pulse, exec_inst, ovf, busy
  );

  modport slave (
    input  inst, inst_vld, tx_rdy,
    output inst_rdy, tx_data, tx_vld, exec_pulse, exec_inst, ovf, busy
  );

endinterface

// File: rtl/calc_send_fifo.sv
// calc_send_fifo
//   Synchronous FIFO that holds the SEND results waiting for the transmitter.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     push_i, data_i write an entry (ignored while full)
//     pop_i          remove the head entry (ignored while empty)
//     data_o         current head entry
//     full_o         no free entry left
//     empty_o        no entry held
//   A push and a pop in the same cycle leave the count unchanged.
module calc_send_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [AW:0]       count_q, count_d;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  // The pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so that the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/calc_exec_core.sv
// calc_exec_core
//   Execution core of the switch/UART calculator. It takes {op, ra, rb, rc}
//   instructions over a valid/ready handshake and runs them against an
//   NREG x DATA_W register file. SEND results are queued for the UART
//   transmitter.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     bus         calc_if slave: inst/inst_vld/inst_rdy, tx_data/tx_vld/tx_rdy,
//                 exec_pulse/exec_inst retire report, sticky ovf, busy
//   Build option CALC_SAT_EN: when it is defined, ADD and MULT clamp to all
//   ones on overflow. Otherwise they wrap. ovf is set in both builds.
module calc_exec_core
  import calc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NREG       = 4,
  parameter int SEND_DEPTH = 4
) (
  input logic   clk,
  input logic   rst_n,
  calc_if.slave bus
);

  localparam int RIDX_W = ridx_w(NREG);
  localparam int INST_W = inst_w(NREG);
  localparam int IMM_W  = imm_w(NREG);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  logic [1:0]          op;
  logic [RIDX_W-1:0]   ra, rb, rc;
  logic                accept;

  calc_state_e         state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic                ovf_q, ovf_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RIDX_W-1:0]   mulRc_q, mulRc_d;
  logic [INST_W-1:0]   mulInst_q, mulInst_d;
  logic                execPulse_q, execPulse_d;
  logic [INST_W-1:0]   execInst_q, execInst_d;

  logic [DATA_W-1:0]   opA, opB;
  logic [DATA_W-1:0]   pushVal, addRes, mulRes;
  logic [DATA_W:0]     addSum;
  logic [2*DATA_W-1:0] prodNext;
  logic                addOvf, mulOvf;

  logic                fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic [DATA_W-1:0]   fifoData;

  assign {op, ra, rb, rc} = bus.inst;
  assign accept = bus.inst_vld && bus.inst_rdy;

  assign opA = regs_q[ra];
  assign opB = regs_q[rb];

  // PUSH shifts the {rb, rc} immediate in at the LSB end. The top bits fall
  // off without touching ovf.
  assign pushVal = (opA << IMM_W) | DATA_W'({rb, rc});

  assign addSum   = {1'b0, opA} + {1'b0, opB};
  assign addOvf   = addSum[DATA_W];

  // One shift-add step. The multiplicand moves left while the multiplier
  // moves right, so bit 0 always selects the current partial product.
  assign prodNext = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mulOvf   = |prodNext[2*DATA_W-1:DATA_W];

`ifdef CALC_SAT_EN
  assign addRes = addOvf ? '1 : addSum[DATA_W-1:0];
  assign mulRes = mulOvf ? '1 : prodNext[DATA_W-1:0];
`else
  assign addRes = addSum[DATA_W-1:0];
  assign mulRes = prodNext[DATA_W-1:0];
`endif

  // Single-cycle ops write at the edge that accepts them. MULT latches its
  // operands and target and then iterates in MUL. The register file is only
  // written on the final iteration.
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    mulRc_d     = mulRc_q;
    mulInst_d   = mulInst_q;
    execPulse_d = 1'b0;
    execInst_d  = execInst_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_PUSH: regs_d[ra] = pushVal;
            OP_ADD: begin
              regs_d[rc] = addRes;
              if (addOvf) ovf_d = 1'b1;
            end
            OP_MULT: begin
              mcand_d   = {{DATA_W{1'b0}}, opA};
              mplier_d  = opB;
              prod_d    = '0;
              cnt_d     = '0;
              mulRc_d   = rc;
              mulInst_d = bus.inst;
              state_d   = MUL;
            end
            default: ;
          endcase
          if (op != OP_MULT) begin
            execPulse_d = 1'b1;
            execInst_d  = bus.inst;
          end
        end
      end
      MUL: begin
        prod_d   = prodNext;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          regs_d[mulRc_q] = mulRes;
          if (mulOvf) ovf_d = 1'b1;
          execPulse_d = 1'b1;
          execInst_d  = mulInst_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      ovf_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      mulRc_q     <= '0;
      mulInst_q   <= '0;
      execPulse_q <= 1'b0;
      execInst_q  <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      ovf_q       <= ovf_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      mulRc_q     <= mulRc_d;
      mulInst_q   <= mulInst_d;
      execPulse_q <= execPulse_d;
      execInst_q  <= execInst_d;
    end
  end

  // A full queue stalls every opcode, so a SEND can never be accepted
  // without a free entry.
  assign fifoPush = accept && (op == OP_SEND);
  assign fifoPop  = !fifoEmpty && bus.tx_rdy;

  calc_send_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (SEND_DEPTH)
  ) u_send_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifoPush),
    .data_i  (opA),
    .pop_i   (fifoPop),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign bus.inst_rdy   = (state_q == IDLE) && !fifoFull;
  assign bus.busy       = (state_q == MUL);
  assign bus.tx_vld     = !fifoEmpty;
  assign bus.tx_data    = fifoData;
  assign bus.exec_pulse = execPulse_q;
  assign bus.exec_inst  = execInst_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_calc_exec_core.sv
// tb_calc_exec_core
//   Self-checking bench for calc_exec_core with the default parameters
//   (DATA_W 8, NREG 4, SEND_DEPTH 4). Expected register contents come from an
//   arithmetic model of the instruction set. Expected transmitter traffic is
//   kept in a FIFO queue. Define CALC_SAT_EN to check the saturating build.
module tb_calc_exec_core;

  localparam int DATA_W     = 8;
  localparam int NREG       = 4;
  localparam int SEND_DEPTH = 4;

`ifdef CALC_SAT_EN
  localparam int ADD_OVF_EXP = 255;
  localparam int MUL_OVF_EXP = 255;
`else
  localparam int ADD_OVF_EXP = 0;
  localparam int MUL_OVF_EXP = 1;
`endif

  typedef struct {
    logic [7:0] inst;
    int         sendExp;
    bit         expOvf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;
  int   cycleCnt;

  int   mReg [NREG];
  bit   mOvf;
  int   expQ [$];

  calc_if #(.DATA_W(DATA_W), .NREG(NREG)) bus ();

  calc_exec_core #(
    .DATA_W     (DATA_W),
    .NREG       (NREG),
    .SEND_DEPTH (SEND_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Every comparison goes through this task so that the counters stay in step.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] mk(input int op, input int ra, input int rb, input int rc);
    logic [7:0] v;
    v = {op[1:0], ra[1:0], rb[1:0], rc[1:0]};
    return v;
  endfunction

  function automatic int clampRes(input int r);
`ifdef CALC_SAT_EN
    return (r > 255) ? 255 : r;
`else
    return r % 256;
`endif
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NREG; i++) mReg[i] = 0;
    mOvf = 1'b0;
    expQ.delete();
  endfunction

  // Transmit monitor. It samples between edges, so the values seen are the
  // ones the next rising edge acts on.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      checkOutput("txVld", bus.tx_vld, expQ.size() != 0);
      if (bus.tx_vld && bus.tx_rdy) begin
        if (expQ.size() == 0) checkOutput("txUnexpectedPop", 1, 0);
        else                  checkOutput("txData", bus.tx_data, expQ.pop_front());
      end
    end
  end

  // Offers one instruction, waits for it to be accepted and, for a MULT,
  // for it to retire. It then checks the retire report. A non-negative
  // sendExp overrides the model's value for SEND.
  task automatic applyStimulus(input logic [7:0] ins, input int sendExp);
    int op, ra, rb, rc, a, b, waitCnt, busyCnt, rdyLowCnt;
    op = int'(ins[7:6]);
    ra = int'(ins[5:4]);
    rb = int'(ins[3:2]);
    rc = int'(ins[1:0]);
    bus.inst     = ins;
    bus.inst_vld = 1'b1;
    waitCnt = 0;
    while (!bus.inst_rdy && waitCnt < 64) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.inst_rdy) begin
      checkOutput("acceptTimeout", 0, 1);
      bus.inst_vld = 1'b0;
      return;
    end
    @(negedge clk);
    bus.inst_vld = 1'b0;
    a = mReg[ra];
    b = mReg[rb];
    case (op)
      0: mReg[ra] = (a * 16 + rb * 4 + rc) % 256;
      1: begin
        if (a + b > 255) mOvf = 1'b1;
        mReg[rc] = clampRes(a + b);
      end
      2: begin
        if (a * b > 255) mOvf = 1'b1;
        mReg[rc] = clampRes(a * b);
      end
      default: expQ.push_back((sendExp < 0) ? a : sendExp);
    endcase
    if (op == 2) begin
      busyCnt   = 0;
      rdyLowCnt = 0;
      while (bus.busy && busyCnt < 64) begin
        busyCnt++;
        if (!bus.inst_rdy) rdyLowCnt++;
        @(negedge clk);
      end
      checkOutput("mulBusyCycles", busyCnt, DATA_W);
      checkOutput("mulRdyLowCycles", rdyLowCnt, DATA_W);
      checkOutput("rdyAfterMul", bus.inst_rdy, expQ.size() < SEND_DEPTH);
    end
    checkOutput("execPulse", bus.exec_pulse, 1);
    checkOutput("execInst", bus.exec_inst, ins);
    checkOutput("ovf", bus.ovf, mOvf);
  endtask

  task automatic drainQueue();
    int n;
    n = 0;
    bus.tx_rdy = 1'b1;
    while ((expQ.size() != 0 || bus.tx_vld) && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainLeft", expQ.size(), 0);
    checkOutput("drainTxVld", bus.tx_vld, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [9];
    int   c0;

    assertCount  = 0;
    failCount    = 0;
    cycleCnt     = 0;
    rst_n        = 1'b0;
    bus.inst     = '0;
    bus.inst_vld = 1'b0;
    bus.tx_rdy   = 1'b1;
    modelReset();

    // Reset values after two cycles with rst_n held low.
    repeat (2) @(negedge clk);
    checkOutput("rstInstRdy", bus.inst_rdy, 1);
    checkOutput("rstTxVld", bus.tx_vld, 0);
    checkOutput("rstTxData", bus.tx_data, 0);
    checkOutput("rstExecPulse", bus.exec_pulse, 0);
    checkOutput("rstExecInst", bus.exec_inst, 0);
    checkOutput("rstOvf", bus.ovf, 0);
    checkOutput("rstBusy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] register file after reset");
    for (int r = 0; r < NREG; r++) applyStimulus(mk(3, r, 0, 0), 0);
    drainQueue();

    $display("[TB] arithmetic table with transmitter stalled");
    tbl[0] = '{mk(0, 0, 1, 0), -1, 1'b0};
    tbl[1] = '{mk(0, 0, 0, 0), -1, 1'b0};
    tbl[2] = '{mk(0, 1, 0, 3), -1, 1'b0};
    tbl[3] = '{mk(2, 0, 1, 2), -1, 1'b0};
    tbl[4] = '{mk(1, 2, 0, 3), -1, 1'b1};
    tbl[5] = '{mk(3, 0, 0, 0), 8'h40, 1'b1};
    tbl[6] = '{mk(3, 1, 0, 0), 8'h03, 1'b1};
    tbl[7] = '{mk(3, 2, 0, 0), 8'hC0, 1'b1};
    tbl[8] = '{mk(3, 3, 0, 0), ADD_OVF_EXP, 1'b1};
    bus.tx_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].inst, tbl[i].sendExp);
      checkOutput("tblOvf", bus.ovf, tbl[i].expOvf);
    end

    $display("[TB] queue full backpressure");
    bus.inst     = mk(3, 0, 0, 0);
    bus.inst_vld = 1'b1;
    checkOutput("fullStallRdy0", bus.inst_rdy, 0);
    repeat (2) @(negedge clk);
    checkOutput("fullStallRdy2", bus.inst_rdy, 0);
    bus.tx_rdy = 1'b1;
    @(negedge clk);
    bus.tx_rdy = 1'b0;
    checkOutput("afterPopRdy", bus.inst_rdy, 1);
    @(negedge clk);
    bus.inst_vld = 1'b0;
    expQ.push_back(8'h40);
    checkOutput("stalledSendPulse", bus.exec_pulse, 1);
    checkOutput("stalledSendInst", bus.exec_inst, mk(3, 0, 0, 0));
    drainQueue();

    $display("[TB] back-to-back throughput");
    c0 = cycleCnt;
    applyStimulus(mk(0, 1, 0, 1), -1);
    applyStimulus(mk(0, 1, 0, 2), -1);
    applyStimulus(mk(0, 1, 0, 3), -1);
    checkOutput("threePushCycles", cycleCnt - c0, 3);
    @(negedge clk);
    checkOutput("pulseDropsAfter", bus.exec_pulse, 0);

    $display("[TB] reset during multiply");
    bus.inst     = mk(2, 0, 1, 2);
    bus.inst_vld = 1'b1;
    checkOutput("midMulAcceptRdy", bus.inst_rdy, 1);
    @(negedge clk);
    bus.inst_vld = 1'b0;
    checkOutput("midMulBusy", bus.busy, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("midMulRstBusy", bus.busy, 0);
    checkOutput("midMulRstRdy", bus.inst_rdy, 1);
    checkOutput("midMulRstPulse", bus.exec_pulse, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstPulse", bus.exec_pulse, 0);
    applyStimulus(mk(3, 2, 0, 0), 0);
    drainQueue();

    $display("[TB] multiply boundary products");
    applyStimulus(mk(0, 0, 0, 0), -1);
    applyStimulus(mk(0, 0, 3, 3), -1);
    applyStimulus(mk(0, 1, 0, 1), -1);
    applyStimulus(mk(0, 1, 0, 1), -1);
    applyStimulus(mk(2, 0, 1, 2), -1);
    checkOutput("mul0Fx11Ovf", bus.ovf, 0);
    applyStimulus(mk(3, 2, 0, 0), 8'hFF);
    applyStimulus(mk(0, 0, 3, 3), -1);
    applyStimulus(mk(2, 0, 0, 3), -1);
    checkOutput("mulFFxFFOvf", bus.ovf, 1);
    applyStimulus(mk(3, 3, 0, 0), MUL_OVF_EXP);
    drainQueue();

    $display("[TB] randomized instruction stream");
    for (int i = 0; i < 300; i++) begin
      bus.tx_rdy = (expQ.size() >= SEND_DEPTH) ? 1'b1 : ($urandom_range(0, 3) != 0);
      applyStimulus(8'($urandom_range(0, 255)), -1);
    end
    for (int r = 0; r < NREG; r++) applyStimulus(mk(3, r, 0, 0), -1);
    drainQueue();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
